// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, frame bit levels and a parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Expected parity bit from the XOR of the data bits (par_odd: 0 = even, 1 = odd).
    function automatic logic expected_parity(input logic data_xor, input logic par_odd);
        return data_xor ^ par_odd;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, per-bit edge/bit counters and bit-value sampler for uart_rx.
// Define UART_RX_MAJ_VOTE_EN for 3-sample majority voting around the bit centre.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic clk,
    input  logic srst,
    input  logic rx_in,
    input  logic run,
    output logic rx_sync,
    output logic sample_tick,
    output logic bit_end,
    output logic data_last,
    output logic bit_val,
    output logic last_bit
);

    localparam int ECW = $clog2(PRESCALE);
    localparam int BCW = $clog2(DATA_WIDTH + 3);
    localparam logic [ECW-1:0] HALF      = ECW'(PRESCALE / 2);
    localparam logic [ECW-1:0] LAST      = ECW'(PRESCALE - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_WIDTH);

    logic [1:0]     sync_q, sync_d;
    logic [ECW-1:0] edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic           last_bit_q, last_bit_d;

    assign rx_sync     = sync_q[1];
    assign sample_tick = (edge_cnt_q == HALF);
    assign bit_end     = (edge_cnt_q == LAST);
    assign data_last   = (bit_cnt_q == DATA_LAST);
    assign last_bit    = last_bit_q;

`ifdef UART_RX_MAJ_VOTE_EN
    localparam logic [ECW-1:0] EARLY = ECW'(PRESCALE / 2 - 1);
    logic early_q, early_d;

    // The sample after the centre is already in the first sync flop, so the vote
    // resolves at the centre edge count without delaying the decision.
    always_comb begin
        early_d = (edge_cnt_q == EARLY) ? sync_q[1] : early_q;
        bit_val = (early_q & sync_q[1]) | (early_q & sync_q[0]) | (sync_q[1] & sync_q[0]);
    end

    always_ff @(posedge clk) begin
        if (srst) early_q <= STOP_BIT;
        else      early_q <= early_d;
    end
`else
    assign bit_val = sync_q[1];
`endif

    always_comb begin
        sync_d     = {sync_q[0], rx_in};
        last_bit_d = sample_tick ? bit_val : last_bit_q;
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (run) begin
            if (bit_end) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end else begin
                edge_cnt_d = edge_cnt_q + 1'b1;
                bit_cnt_d  = bit_cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_q     <= {2{STOP_BIT}};
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            last_bit_q <= STOP_BIT;
        end else begin
            sync_q     <= sync_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            last_bit_q <= last_bit_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: frame FSM, deserializer, parity/stop checking and result pulses.
// Sampling scheme is selected in uart_rx_sampler by UART_RX_MAJ_VOTE_EN (majority vote when defined).
module uart_rx
    import uart_pkg::*;
#(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    logic rx_sync, sample_tick, bit_end, data_last, bit_val, last_bit, run;

    uart_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_bad_q, par_bad_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    // Counters run for every cycle the FSM is (or is about to be) inside a frame.
    assign run = (state_d != ST_IDLE);

    uart_rx_sampler #(
        .PRESCALE   (PRESCALE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sampler (
        .clk         (CLK),
        .srst        (RST),
        .rx_in       (RX_IN),
        .run         (run),
        .rx_sync     (rx_sync),
        .sample_tick (sample_tick),
        .bit_end     (bit_end),
        .data_last   (data_last),
        .bit_val     (bit_val),
        .last_bit    (last_bit)
    );

    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (rx_sync == START_BIT) state_d = ST_START;
            ST_START:  if (bit_end) state_d = (last_bit == START_BIT) ? ST_DATA : ST_IDLE;
            ST_DATA:   if (bit_end && data_last) state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (sample_tick) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_bad_d    = par_bad_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_sync == START_BIT) begin
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_bad_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (sample_tick) shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
            end
            ST_PARITY: begin
                if (sample_tick) par_bad_d = (bit_val != expected_parity(^shift_q, par_typ_q));
            end
            ST_STOP: begin
                if (sample_tick) begin
                    stp_err_d    = (bit_val != STOP_BIT);
                    par_err_d    = par_bad_q;
                    data_valid_d = (bit_val == STOP_BIT) && !par_bad_q;
                    if (data_valid_d) p_data_d = shift_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_q      <= '0;
            p_data_q     <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_Valid = data_valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames against a frame-level model.
module tb_uart_rx;

    localparam int P  = 8;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          PAR_ERR;
    logic          STP_ERR;

    uart_rx #(
        .PRESCALE   (P),
        .DATA_WIDTH (DW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        bit          dv;
        bit          pe;
        bit          se;
        logic [DW-1:0] pd;
    } ev_t;

    ev_t           obs_q[$];
    ev_t           exp_q[$];
    ev_t           mon_ev;
    int            cyc = 0;
    int            vec_cnt = 0;
    int            err_cnt = 0;
    logic [DW-1:0] model_pdata = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Every cycle with any result pulse high becomes one observed event.
    always @(negedge CLK) begin
        if (Data_Valid === 1'b1 || PAR_ERR === 1'b1 || STP_ERR === 1'b1) begin
            mon_ev.cyc = cyc;
            mon_ev.dv  = Data_Valid;
            mon_ev.pe  = PAR_ERR;
            mon_ev.se  = STP_ERR;
            mon_ev.pd  = P_DATA;
            obs_q.push_back(mon_ev);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vec_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Frame-level reference: outcome and timing follow from the frame contents alone.
    function automatic void model_frame(input int t0, input logic [DW-1:0] d, input bit pen,
                                        input bit ptyp, input bit pbit, input bit sbit);
        ev_t ev;
        int  nbits_before_stop;
        int  req;
        nbits_before_stop = 1 + DW + (pen ? 1 : 0);
        req    = ($countones(d) % 2) ^ (ptyp ? 1 : 0);
        ev.pe  = pen && ((pbit ? 1 : 0) != req);
        ev.se  = !sbit;
        ev.dv  = !ev.pe && !ev.se;
        if (ev.dv) model_pdata = d;
        ev.pd  = model_pdata;
        ev.cyc = t0 + nbits_before_stop * P + P / 2 + 1;
        exp_q.push_back(ev);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
            RX_IN = 1'b1;
        end
    endtask

    // Drives one frame; rst_bit >= 0 pulses RST mid-bit at that line bit and aborts the frame.
    task automatic send_frame(input logic [DW-1:0] d, input bit pen, input bit ptyp,
                              input bit pbit, input bit sbit, input int rst_bit);
        logic [DW+2:0] bits;
        int            nb;
        int            drv;
        bits        = '1;
        bits[0]     = 1'b0;
        bits[DW:1]  = d;
        if (pen) begin
            bits[DW+1] = pbit;
            bits[DW+2] = sbit;
            nb = DW + 3;
        end else begin
            bits[DW+1] = sbit;
            nb = DW + 2;
        end
        drv     = 0;
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        for (int b = 0; b < nb; b++) begin
            for (int e = 0; e < P; e++) begin
                @(posedge CLK); #1;
                if (b == 0 && e == 0) drv = cyc;
                if (b == 1 && e == 0) begin
                    PAR_EN  = 1'($urandom);
                    PAR_TYP = 1'($urandom);
                end
                if (b == rst_bit && e == P / 2) begin
                    RST   = 1'b1;
                    RX_IN = 1'b1;
                    @(posedge CLK); #1;
                    RST = 1'b0;
                    model_pdata = '0;
                    @(negedge CLK);
                    check("mid_rst/P_DATA", 32'(P_DATA), 32'(0));
                    check("mid_rst/Data_Valid", 32'(Data_Valid), 32'(0));
                    check("mid_rst/PAR_ERR", 32'(PAR_ERR), 32'(0));
                    check("mid_rst/STP_ERR", 32'(STP_ERR), 32'(0));
                    return;
                end
                RX_IN = bits[b];
            end
        end
        // The synchronizer puts the first low sample two cycles after the line falls.
        model_frame(drv + 2, d, pen, ptyp, pbit, sbit);
    endtask

    task automatic compare_events(input string name);
        ev_t o;
        ev_t e;
        check({name, "/n_events"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({name, "/cycle"}, 32'(o.cyc), 32'(e.cyc));
            check({name, "/Data_Valid"}, 32'(o.dv), 32'(e.dv));
            check({name, "/PAR_ERR"}, 32'(o.pe), 32'(e.pe));
            check({name, "/STP_ERR"}, 32'(o.se), 32'(e.se));
            check({name, "/P_DATA"}, 32'(o.pd), 32'(e.pd));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [DW-1:0] rd;
        bit            rpen, rptyp, rpbit, rsbit;
        int            req;
        int            gap;

        RST     = 1'b1;
        RX_IN   = 1'b1;
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        repeat (4) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("reset/P_DATA", 32'(P_DATA), 32'(0));
        check("reset/Data_Valid", 32'(Data_Valid), 32'(0));
        check("reset/PAR_ERR", 32'(PAR_ERR), 32'(0));
        check("reset/STP_ERR", 32'(STP_ERR), 32'(0));
        idle(2 * P);

        send_frame(8'h8F, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        idle(2 * P);
        compare_events("even_par");

        send_frame(8'hA8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(2 * P);
        compare_events("no_par");

        send_frame(8'h8F, 1'b1, 1'b1, 1'b1, 1'b1, -1);
        idle(2 * P);
        compare_events("par_err");

        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(3 * P);
        compare_events("stop_err");

        @(posedge CLK); #1 RX_IN = 1'b0;
        @(posedge CLK); #1 RX_IN = 1'b0;
        @(posedge CLK); #1 RX_IN = 1'b1;
        idle(3 * P);
        compare_events("glitch");
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(2 * P);
        compare_events("after_glitch");

        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 4);
        idle(3 * P);
        compare_events("mid_rst");
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(2 * P);
        compare_events("after_rst");

        for (int i = 0; i < 40; i++) begin
            rd    = DW'($urandom);
            rpen  = 1'($urandom);
            rptyp = 1'($urandom);
            req   = ($countones(rd) % 2) ^ (rptyp ? 1 : 0);
            rpbit = ($urandom_range(0, 5) == 0) ? (req == 0) : (req == 1);
            rsbit = ($urandom_range(0, 7) != 0);
            send_frame(rd, rpen, rptyp, rpbit, rsbit, -1);
            if (!rsbit)                         gap = $urandom_range(2 * P, 3 * P);
            else if ($urandom_range(0, 2) == 0) gap = 0;
            else                                gap = $urandom_range(1, 2 * P);
            idle(gap);
        end
        idle(3 * P);
        compare_events("random");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
